// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int TT_ROWS  = 16;
  localparam int TT_ROW_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } tt_state_e;

  // Row of the most significant differing bit (bit 15 is row 0); 0 when equal.
  function automatic logic [TT_ROW_W-1:0] tt_first_mismatch(
    input logic [TT_ROWS-1:0] meas,
    input logic [TT_ROWS-1:0] exp_tt
  );
    logic [TT_ROWS-1:0]  diff;
    logic [TT_ROW_W-1:0] row;
    diff = meas ^ exp_tt;
    row  = '0;
    for (int i = 0; i < TT_ROWS; i++) begin
      if (diff[i]) row = TT_ROW_W'(TT_ROWS - 1 - i);
    end
    return row;
  endfunction

endpackage

// File: rtl/tt_sweep_controller_settle_timer.sv
// Loadable settle down-counter; optional TT_SWEEP_STABILITY_CHECK_EN adds a
// flag marking the tail of the final stability window.
module tt_settle_timer #(
  parameter int unsigned WINDOW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       dec,
  output logic       expired
`ifdef TT_SWEEP_STABILITY_CHECK_EN
  ,
  output logic       window_tail
`endif
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign expired = (count == 8'd1);

`ifdef TT_SWEEP_STABILITY_CHECK_EN
  // Window cycles after the first one, where a change can be observed.
  assign window_tail = (count != 8'd0) && (count < 8'(WINDOW));
`endif

endmodule

// File: rtl/tt_sweep_controller.sv
// Exhaustive 16-row sweep of a 4-input circuit with truth-table compare.
// Optional output-stability monitor: TT_SWEEP_STABILITY_CHECK_EN.
module tt_sweep_controller
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED_TT   = 16'h0643
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        out_sample,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt_result,
  output logic [3:0]  fail_row
`ifdef TT_SWEEP_STABILITY_CHECK_EN
  ,
  output logic        unstable
`endif
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("tt_sweep_controller: SETTLE_CYCLES must be in 1..255");
    end
  endgenerate

  localparam int unsigned STAB_WIN = (SETTLE_CYCLES < 2) ? SETTLE_CYCLES : 2;

  tt_state_e             state;
  logic [TT_ROW_W-1:0]   row;
  logic [TT_ROW_W-1:0]   drive;
  logic                  settle_expired;

  assign {in1, in2, in3, in4} = drive;

`ifdef TT_SWEEP_STABILITY_CHECK_EN
  logic window_tail;
  logic out_prev;
  logic stab_glitch;

  tt_settle_timer #(.WINDOW(STAB_WIN)) u_settle_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (state == DRIVE),
    .load_value  (8'(SETTLE_CYCLES)),
    .dec         (state == SETTLE),
    .expired     (settle_expired),
    .window_tail (window_tail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_prev <= 1'b0;
    else     out_prev <= out_sample;
  end

  assign stab_glitch = (((state == SETTLE) && window_tail) || (state == SAMPLE))
                       && (out_sample != out_prev);
`else
  tt_settle_timer #(.WINDOW(STAB_WIN)) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (state == DRIVE),
    .load_value (8'(SETTLE_CYCLES)),
    .dec        (state == SETTLE),
    .expired    (settle_expired)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      drive     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      tt_result <= '0;
      fail_row  <= '0;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
      unstable  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        // Partial capture in tt_result is deliberately kept.
        state <= IDLE;
        drive <= '0;
        busy  <= 1'b0;
        pass  <= 1'b0;
      end else begin
`ifdef TT_SWEEP_STABILITY_CHECK_EN
        if (stab_glitch) unstable <= 1'b1;
`endif
        case (state)
          IDLE: begin
            drive <= '0;
            if (start && !abort) begin
              state     <= DRIVE;
              row       <= '0;
              tt_result <= '0;
              pass      <= 1'b0;
              fail_row  <= '0;
              busy      <= 1'b1;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
              unstable  <= 1'b0;
`endif
            end
          end
          DRIVE:  state <= SETTLE;
          SETTLE: if (settle_expired) state <= SAMPLE;
          SAMPLE: begin
            tt_result[4'd15 - row] <= out_sample;
            if (row == 4'd15) begin
              state <= FINISH;
            end else begin
              row   <= row + 4'd1;
              drive <= row + 4'd1;
              state <= DRIVE;
            end
          end
          FINISH: begin
            done     <= 1'b1;
            busy     <= 1'b0;
            drive    <= '0;
            fail_row <= tt_first_mismatch(tt_result, EXPECTED_TT);
`ifdef TT_SWEEP_STABILITY_CHECK_EN
            pass     <= (tt_result == EXPECTED_TT) && !unstable;
`else
            pass     <= (tt_result == EXPECTED_TT);
`endif
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/tt_sweep_controller.md
Name: tt_sweep_controller

Overview:
- Sequencer that exhaustively exercises one 4-input combinational logic circuit, such as the 0x0643 NOR/NOT netlist family.
- Drives in1..in4 through all 16 input rows and waits a programmable settle time per row to model gate propagation.
- Samples the circuit output once per row, assembles the measured 16-bit truth table and compares it against an expected hex code.
- Sits between a test/host controller and the circuit instance.

Parameters:
- SETTLE_CYCLES, 4, cycles the inputs are held stable before the output is sampled; legal range 1..255, elaboration error otherwise.
- EXPECTED_TT, 16'h0643, expected truth table in Cello order: bit 15 = row 0, bit 0 = row 15.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request; accepted only in IDLE.
- abort  input  1  cancels a running sweep.
- out_sample  input  1  output of the circuit under control.
- in1  output  1  circuit input; row index bit 3 (MSB).
- in2  output  1  circuit input; row index bit 2.
- in3  output  1  circuit input; row index bit 1.
- in4  output  1  circuit input; row index bit 0 (LSB).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  measured table == EXPECTED_TT; valid from done onward.
- tt_result  output  16  measured truth table.
- fail_row  output  4  lowest row index that mismatched; 0 when pass.

Behaviour:
- Reset: one clock clk; reset rst is asynchronous and active-high.
  - While rst is high: state=IDLE; in1..in4=0, busy=0, done=0, pass=0, tt_result=0, fail_row=0.
  - rst asserted mid-sweep aborts immediately, with the same values.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - in1..in4=0.
  - start=1 and abort=0: go to DRIVE, set row=0, clear tt_result, set busy=1.
  - start while busy is ignored; no queuing.
- DRIVE (1 cycle): {in1,in2,in3,in4}=row; load settle counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE: hold the row; count down; go to SAMPLE on the cycle the counter reaches 1. This state lasts SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - Capture tt_result[15-row] = out_sample.
  - If row==15, go to FINISH; otherwise row+1 and go to DRIVE.
  - row is 4 bits; it never wraps during a sweep.
- FINISH (1 cycle):
  - done=1; busy=0.
  - pass=(tt_result==EXPECTED_TT).
  - fail_row = index of the most significant set bit of (tt_result ^ EXPECTED_TT) mapped to its row (row = 15-bit); 0 if equal.
  - Return to IDLE.
- Latency: start sampled at edge k gives a done pulse in cycle k+1+16*(SETTLE_CYCLES+2). For SETTLE_CYCLES=4 that is k+97.
- Inputs change only on DRIVE entry; they are constant through SETTLE and SAMPLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, busy=0, no done pulse, pass=0.
  - tt_result keeps the partial capture.
  - Simultaneous abort and start in IDLE: stay in IDLE.
- Results (pass, tt_result, fail_row) hold until the next accepted start.

Optional Feature:
- Macro TT_SWEEP_STABILITY_CHECK_EN.
- When defined:
  - Extra output unstable (1 bit), cleared on start.
  - During the last min(2, SETTLE_CYCLES) SETTLE cycles plus the SAMPLE cycle, out_sample must stay constant.
  - Any change sets unstable=1 (sticky) and forces pass=0 at FINISH.
- When not defined: no unstable port and no stability comparison logic; pass depends only on the table compare.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum tt_state_e (IDLE, DRIVE, SETTLE, SAMPLE, FINISH);
  - TT_ROWS=16;
  - TT_ROW_W=4;
  - function tt_first_mismatch(logic[15:0] meas, exp) returning the row index.
- One natural sub-module, tt_settle_timer: loadable down-counter with an expired flag, used by SETTLE.

Test Plan:
- Correct circuit: out_sample from a behavioural 0x0643 model, SETTLE_CYCLES=4, start pulse.
  - Required: done at k+97, tt_result=16'h0643, pass=1, fail_row=0.
  - Required: rows visited 0..15 in order, each held 6 cycles.
- Faulty circuit: model returns row 5 inverted.
  - Required: tt_result=16'h0243, pass=0, fail_row=5.
- Abort: assert abort during row 7 SETTLE.
  - Required: busy=0 next cycle, no done pulse, in1..in4=0.
  - Required: a new start yields a full sweep with pass=1.
- Start while busy: pulse start at row 3.
  - Required: ignored; a single done pulse at the original time.
- Async reset: assert rst mid-SAMPLE, off a clock edge.
  - Required: all outputs 0 immediately, state IDLE.
- Stability (macro on): toggle out_sample during the last settle cycle of row 9.
  - Required: unstable=1, pass=0, tt_result bit for row 9 still captured.
